// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock controller.
package pll_ctrl_pkg;

    localparam int N_W_DEF = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_e;

    // Width needed to hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pll_lock_window.sv
// Lead/lag window sampler: counts phase-detector pulses over WIN_LEN cycles
// and flags on the last cycle whether the lead/lag imbalance is within LOCK_TOL.
module pll_lock_window
    import pll_ctrl_pkg::*;
#(
    parameter int WIN_LEN  = 16,
    parameter int LOCK_TOL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic lead,
    input  logic lag,
    output logic win_done,
    output logic win_good
);

    localparam int WC_W = $clog2(WIN_LEN);
    localparam int CW   = cnt_w(WIN_LEN);

    logic [WC_W-1:0] win_cnt;
    logic [CW-1:0]   lead_cnt, lag_cnt;
    logic [CW-1:0]   lead_nx, lag_nx, diff;

    // Evaluation includes the sample taken on the terminal cycle.
    assign lead_nx  = lead_cnt + CW'(lead & ~lag);
    assign lag_nx   = lag_cnt + CW'(lag & ~lead);
    assign diff     = (lead_nx >= lag_nx) ? (lead_nx - lag_nx) : (lag_nx - lead_nx);
    assign win_done = !clear && (win_cnt == WC_W'(WIN_LEN - 1));
    assign win_good = (32'(diff) <= LOCK_TOL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt  <= '0;
            lead_cnt <= '0;
            lag_cnt  <= '0;
        end else if (clear || win_done) begin
            win_cnt  <= '0;
            lead_cnt <= '0;
            lag_cnt  <= '0;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            lead_cnt <= lead_nx;
            lag_cnt  <= lag_nx;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// ADPLL sequencing and lock-detect controller.
// Optional lock timeout enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int N_W         = N_W_DEF,
    parameter int N_DEFAULT   = 92,
    parameter int SETTLE_CYC  = 64,
    parameter int WIN_LEN     = 16,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_WINS   = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           cfg_valid,
    input  logic [N_W-1:0] cfg_n,
    output logic           cfg_ready,
    input  logic           lead,
    input  logic           lag,
    output logic           pll_enable,
    output logic [N_W-1:0] pll_n,
    output logic           locked,
    output logic           lock_lost,
    output logic           busy,
    output logic           lock_fail
);

    localparam int SCW = cnt_w(SETTLE_CYC);
    localparam int GW  = cnt_w(LOCK_WINS);

    state_e         state;
    logic [SCW-1:0] settle_cnt;
    logic [GW-1:0]  good_cnt;
    logic           cfg_take, win_clear, win_done, win_good, timeout_hit;

    assign cfg_ready = (state == S_IDLE || state == S_LOCKED) && !stop;
    // Ratios below 2 are swallowed by the handshake and have no effect.
    assign cfg_take  = cfg_valid && cfg_ready && (cfg_n >= N_W'(2));
    assign win_clear = !(state == S_TRACK || state == S_LOCKED) || stop || timeout_hit
                       || (state == S_LOCKED && cfg_take);

    pll_lock_window #(.WIN_LEN(WIN_LEN), .LOCK_TOL(LOCK_TOL)) u_win (
        .clk      (clk),
        .rst      (rst),
        .clear    (win_clear),
        .lead     (lead),
        .lag      (lag),
        .win_done (win_done),
        .win_good (win_good)
    );

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT_CYC);
    logic [TW-1:0] to_cnt;
    logic          to_restart, to_run, fail_q;

    assign to_run      = (state == S_SETTLE || state == S_TRACK);
    assign timeout_hit = to_run && !stop && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign to_restart  = !stop && ((state == S_IDLE && start)
                         || (state == S_LOCKED && (cfg_take || (win_done && !win_good))));
    assign lock_fail   = fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            fail_q <= 1'b0;
        end else begin
            if (to_restart)  to_cnt <= '0;
            else if (to_run) to_cnt <= to_cnt + 1'b1;
            if (!stop && state == S_IDLE && start) fail_q <= 1'b0;
            else if (timeout_hit)                  fail_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign lock_fail   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pll_enable <= 1'b0;
            pll_n      <= N_W'(N_DEFAULT);
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            busy       <= 1'b0;
            settle_cnt <= '0;
            good_cnt   <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (cfg_take) pll_n <= cfg_n;
            if (stop || timeout_hit) begin
                // Stop in IDLE (including with start) is a no-op.
                if (state != S_IDLE) begin
                    state      <= S_IDLE;
                    pll_enable <= 1'b0;
                    locked     <= 1'b0;
                    busy       <= 1'b0;
                    settle_cnt <= '0;
                    good_cnt   <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state      <= S_SETTLE;
                        pll_enable <= 1'b1;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
                            state      <= S_TRACK;
                            settle_cnt <= '0;
                            good_cnt   <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_TRACK: if (win_done) begin
                        if (!win_good) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GW'(LOCK_WINS - 1)) begin
                            state    <= S_LOCKED;
                            locked   <= 1'b1;
                            busy     <= 1'b0;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        // A new ratio forces a full re-settle, silently.
                        if (cfg_take) begin
                            state      <= S_SETTLE;
                            locked     <= 1'b0;
                            busy       <= 1'b1;
                            settle_cnt <= '0;
                        end else if (win_done && !win_good) begin
                            state     <= S_TRACK;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            busy      <= 1'b1;
                            good_cnt  <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
Sequencing and lock-detect controller for the all-digital PLL (DCO, divider, lead/lag phase detector). Enables the PLL, programs the feedback divide ratio N, and waits a settle interval. It then judges lock from the phase-detector lead/lag pulses over fixed windows and reports locked, lock-lost and (optionally) lock-fail to system control. Runs in the reference-clock domain; lead/lag arrive synchronous to clk.

Parameters:
N_W, 7, width of divide ratio
N_DEFAULT, 92, pll_n value after reset
SETTLE_CYC, 64, clk cycles with pll_enable high before lock tracking starts (>=1)
WIN_LEN, 16, clk cycles per lock-evaluation window (>=2)
LOCK_TOL, 2, max |lead_cnt - lag_cnt| for a good window
LOCK_WINS, 4, consecutive good windows required to declare lock
TIMEOUT_CYC, 4096, cycles from SETTLE entry to lock before failure (used only with macro)

Ports:
clk  in  1  reference clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to enable and lock the PLL
stop  in  1  single-cycle request to disable the PLL
cfg_valid  in  1  new divide ratio offered
cfg_n  in  N_W  new divide ratio
cfg_ready  out  1  cfg accepted when cfg_valid && cfg_ready
lead  in  1  phase-detector lead pulse
lag  in  1  phase-detector lag pulse
pll_enable  out  1  PLL enable
pll_n  out  N_W  divide ratio to PLL
locked  out  1  lock declared
lock_lost  out  1  one-cycle pulse on loss of lock
busy  out  1  state is SETTLE or TRACK
lock_fail  out  1  sticky timeout flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports named clk and rst. All outputs are registered except cfg_ready.
- Reset values: state IDLE, pll_enable 0, pll_n N_DEFAULT, locked 0, lock_lost 0, busy 0, lock_fail 0, all counters 0.
- FSM states: IDLE, SETTLE, TRACK, LOCKED.
- IDLE: on start go to SETTLE, with pll_enable 1 from that edge; lock_fail clears.
- SETTLE: settle counter runs 0..SETTLE_CYC-1. At terminal count go to TRACK with window counter, lead_cnt, lag_cnt and good_cnt all 0.
- Window sampling (TRACK and LOCKED):
  - Window counter runs 0..WIN_LEN-1 and wraps.
  - Each cycle: lead&&!lag increments lead_cnt; lag&&!lead increments lag_cnt; both high or neither counts nothing.
  - At count WIN_LEN-1, evaluate including that cycle's sample. Good means |lead_cnt - lag_cnt| <= LOCK_TOL, compared unsigned using clog2(WIN_LEN+1)-bit counters. Counters then clear.
- TRACK: a good window increments good_cnt; when it reaches LOCK_WINS, go to LOCKED with locked 1. A bad window sets good_cnt to 0.
- LOCKED: a bad window gives locked 0, lock_lost high for exactly 1 cycle, next state TRACK, good_cnt 0.
- Lock timing: the earliest locked rise is SETTLE_CYC + LOCK_WINS*WIN_LEN edges after the edge that sampled start.
- stop: from any non-IDLE state, go to IDLE next edge with pll_enable 0, locked 0, and counters cleared; no lock_lost pulse. stop and start in the same cycle: stop wins. start while not IDLE is ignored.
- Configuration handshake:
  - cfg_ready = (state==IDLE || state==LOCKED) && !stop.
  - Accepted cfg_n with value < 2 is dropped and pll_n is unchanged.
  - Otherwise pll_n = cfg_n on the accept edge.
  - Accept in LOCKED: locked 0 and go to SETTLE (pll_enable stays 1, settle counter 0), with no lock_lost pulse.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- Macro PLL_LOCK_TIMEOUT_EN.
- With macro: a timeout counter clears on SETTLE entry and increments in SETTLE/TRACK. On reaching TIMEOUT_CYC: lock_fail 1 (sticky until next accepted start or rst), state IDLE, pll_enable 0. Counter halts in LOCKED and restarts on any re-entry to SETTLE or TRACK.
- Without macro: no counter; lock_fail is tied 0; TRACK persists indefinitely.

Decomposition:
- Package pll_ctrl_pkg holds:
  - state enum (IDLE, SETTLE, TRACK, LOCKED)
  - N_W default
  - window-counter width function/constant
- Sub-module pll_lock_window holds:
  - window counter, lead/lag counters, and the diff/tolerance compare
  - outputs win_done and win_good; input clear
- The FSM stays in pll_lock_ctrl.

Test Plan:
- Reset, then start with lead/lag alternating every cycle (diff 0): pll_enable rises at the next edge; locked rises exactly 128 edges after start; busy falls at the same edge.
- In LOCKED, drive lead only for 16 cycles (diff 16 > 2): at window end locked goes to 0, lock_lost pulses 1 cycle, state returns to TRACK; resume balanced input and locked returns after 64 more cycles.
- cfg_valid with cfg_n=80 in LOCKED: accepted at once, pll_n=80, locked 0, and relock after 128 cycles. cfg_n=1 in IDLE: accepted, pll_n unchanged at 92.
- Same-cycle start and stop in IDLE: remains IDLE. stop during TRACK: pll_enable 0 next edge with no lock_lost. cfg_valid with stop: not accepted.
- With PLL_LOCK_TIMEOUT_EN and lead held high permanently: lock_fail 1 and pll_enable 0 at 4096 cycles after start; a new start clears lock_fail.
- Assert rst mid-TRACK asynchronously (between edges): all outputs take reset values without waiting for a clock edge, pll_n=92.
